// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared aluop codes, FSM encodings, exception codes and bus widths.
package mem_access_pkg;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int RW  = 5;
    localparam int OPW = 8;

    localparam logic [OPW-1:0] OP_LB  = 8'hE0;
    localparam logic [OPW-1:0] OP_LH  = 8'hE1;
    localparam logic [OPW-1:0] OP_LW  = 8'hE3;
    localparam logic [OPW-1:0] OP_LBU = 8'hE4;
    localparam logic [OPW-1:0] OP_LHU = 8'hE5;
    localparam logic [OPW-1:0] OP_SB  = 8'hE8;
    localparam logic [OPW-1:0] OP_SH  = 8'hE9;
    localparam logic [OPW-1:0] OP_SW  = 8'hEB;
    localparam logic [OPW-1:0] OP_LL  = 8'hF0;
    localparam logic [OPW-1:0] OP_SC  = 8'hF8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_ADEL = 2'd1;
    localparam logic [1:0] EXC_ADES = 2'd2;
endpackage

// File: rtl/mem_access_align.sv
// mem_align: load/store decode, byte-lane select, store replication and load extension.
// LL/SC decode only when LLSC_EN is defined.
import mem_access_pkg::*;

module mem_align (
    input  logic [OPW-1:0] aluop,
    input  logic [1:0]     a,
    input  logic [DW-1:0]  reg2,
    input  logic [DW-1:0]  rdata,
    output logic           is_load,
    output logic           is_store,
    output logic           misaligned,
    output logic [3:0]     sel,
    output logic [DW-1:0]  wdata,
    output logic [DW-1:0]  ldata
);
    logic ll, sc, half, word, sgn;
    logic [7:0] b;
    logic [15:0] h;
`ifdef LLSC_EN
    assign ll = aluop == OP_LL;
    assign sc = aluop == OP_SC;
`else
    assign ll = 1'b0;
    assign sc = 1'b0;
`endif
    assign is_load    = (aluop inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW}) || ll;
    assign is_store   = (aluop inside {OP_SB, OP_SH, OP_SW}) || sc;
    assign half       = aluop inside {OP_LH, OP_LHU, OP_SH};
    assign word       = (aluop inside {OP_LW, OP_SW}) || ll || sc;
    assign sgn        = aluop inside {OP_LB, OP_LH};
    assign misaligned = (half && a[0]) || (word && a != 2'b00);
    assign sel        = word ? 4'b1111 : half ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
    assign wdata      = word ? reg2 : half ? {2{reg2[15:0]}} : {4{reg2[7:0]}};
    // Little-endian lanes: byte n of the word lives in bits [8n+7:8n].
    assign b          = rdata[{a, 3'b000} +: 8];
    assign h          = a[1] ? rdata[31:16] : rdata[15:0];
    assign ldata      = word ? rdata : half ? {{16{sgn & h[15]}}, h} : {{24{sgn & b[7]}}, b};
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage with IDLE/BUSY/DONE bus FSM, stall generation and address exceptions.
// Optional LL/SC link-bit support enabled by defining LLSC_EN.
import mem_access_pkg::*;

module mem_access (
    input  logic           clk,
    input  logic           rst,
    input  logic [RW-1:0]  i_wd,
    input  logic           i_wreg,
    input  logic [DW-1:0]  i_wdata,
    input  logic [OPW-1:0] i_aluop,
    input  logic [AW-1:0]  i_addr,
    input  logic [DW-1:0]  i_reg2,
    output logic           bus_req,
    output logic           bus_we,
    output logic [3:0]     bus_sel,
    output logic [AW-1:0]  bus_addr,
    output logic [DW-1:0]  bus_wdata,
    input  logic [DW-1:0]  bus_rdata,
    input  logic           bus_ack,
    output logic [RW-1:0]  o_wd,
    output logic           o_wreg,
    output logic [DW-1:0]  o_wdata,
    output logic           stallreq,
    output logic [1:0]     exc_code
);
    logic [1:0] state;
    logic [DW-1:0] rdata_q, wdata, ldata;
    logic [3:0] sel;
    logic is_load, is_store, misaligned, idle, start, sc_op, sc_ok;

    mem_align u_align (
        .aluop(i_aluop), .a(i_addr[1:0]), .reg2(i_reg2), .rdata(rdata_q),
        .is_load(is_load), .is_store(is_store), .misaligned(misaligned),
        .sel(sel), .wdata(wdata), .ldata(ldata)
    );

`ifdef LLSC_EN
    logic llbit;
    logic [AW-3:0] lladdr;
    assign sc_op = i_aluop == OP_SC;
    assign sc_ok = llbit && lladdr == i_addr[AW-1:2];
    // Any SC seen in IDLE consumes the link, whether it succeeds or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            llbit  <= 1'b0;
            lladdr <= '0;
        end else if (state == S_DONE && i_aluop == OP_LL) begin
            llbit  <= 1'b1;
            lladdr <= i_addr[AW-1:2];
        end else if (idle && sc_op) begin
            llbit  <= 1'b0;
        end
    end
`else
    assign sc_op = 1'b0;
    assign sc_ok = 1'b0;
`endif

    assign idle  = state == S_IDLE;
    assign start = idle && (is_load || is_store) && !misaligned && (!sc_op || sc_ok);

    always_comb begin
        o_wd     = i_wd;
        o_wreg   = i_wreg;
        o_wdata  = i_wdata;
        stallreq = 1'b0;
        exc_code = EXC_NONE;
        if (rst) begin
            o_wd    = '0;
            o_wreg  = 1'b0;
            o_wdata = '0;
        end else if (idle && misaligned) begin
            o_wreg   = 1'b0;
            exc_code = is_load ? EXC_ADEL : EXC_ADES;
        end else if (idle && sc_op && !sc_ok) begin
            o_wreg  = 1'b1;
            o_wdata = '0;
        end else if (start || state == S_BUSY) begin
            o_wreg   = 1'b0;
            stallreq = 1'b1;
        end else if (state == S_DONE) begin
            o_wreg  = is_load ? i_wreg : sc_op;
            o_wdata = is_load ? ldata : sc_op ? 32'd1 : i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata_q   <= '0;
        end else if (start) begin
            state     <= S_BUSY;
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_sel   <= sel;
            bus_addr  <= {i_addr[AW-1:2], 2'b00};
            bus_wdata <= wdata;
        end else if (state == S_BUSY && bus_ack) begin
            state     <= S_DONE;
            bus_req   <= 1'b0;
            rdata_q   <= bus_rdata;
        end else if (state == S_DONE) begin
            state     <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table-driven checks of mem_access transactions plus reset/abort sequences.
// Covers the LL/SC table entries when LLSC_EN is defined.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam logic [31:0] WD = 32'hCAFE_0001;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr, reg2, rdata;
        logic        acc, we;
        logic [3:0]  sel;
        logic [31:0] bwd, owd;
        logic        owreg;
        logic [1:0]  exc;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [4:0] i_wd = 5'd7, o_wd;
    logic i_wreg = 1'b1, o_wreg, bus_req, bus_we, bus_ack = 1'b0, stallreq;
    logic [31:0] i_wdata = WD, i_addr = '0, i_reg2 = '0, bus_rdata = '0;
    logic [31:0] bus_addr, bus_wdata, o_wdata;
    logic [7:0] i_aluop = 8'h25;
    logic [3:0] bus_sel;
    logic [1:0] exc_code;
    int checks = 0, errors = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst), .i_wd(i_wd), .i_wreg(i_wreg), .i_wdata(i_wdata),
        .i_aluop(i_aluop), .i_addr(i_addr), .i_reg2(i_reg2),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .o_wd(o_wd), .o_wreg(o_wreg), .o_wdata(o_wdata),
        .stallreq(stallreq), .exc_code(exc_code)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v);
        i_aluop = v.op; i_addr = v.addr; i_reg2 = v.reg2;
        i_wdata = WD; i_wd = 5'd7; i_wreg = 1'b1; bus_ack = 1'b0;
        #1;
        chk("stall_idle", stallreq, v.acc);
        chk("exc_code", exc_code, v.exc);
        if (!v.acc) begin
            chk("o_wreg_pass", o_wreg, v.owreg);
            chk("o_wd_pass", o_wd, 7);
            if (v.owreg) chk("o_wdata_pass", o_wdata, v.owd);
            tick();
            chk("no_bus_req", bus_req, 0);
            return;
        end
        tick();
        chk("busy_req", bus_req, 1);
        chk("busy_we", bus_we, v.we);
        chk("busy_sel", bus_sel, v.sel);
        chk("busy_addr", bus_addr, {v.addr[31:2], 2'b00});
        chk("busy_wdata", bus_wdata, v.bwd);
        chk("busy_stall", stallreq, 1);
        bus_ack = 1'b1; bus_rdata = v.rdata;
        tick();
        bus_ack = 1'b0; bus_rdata = '0;
        chk("done_req", bus_req, 0);
        chk("done_stall", stallreq, 0);
        chk("done_wreg", o_wreg, v.owreg);
        chk("done_wd", o_wd, 7);
        if (v.owreg) chk("done_wdata", o_wdata, v.owd);
        tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //                op      addr          reg2          rdata         acc  we    sel      bwd           owd           wreg exc
        vq.push_back('{8'h25,  32'h0000_1003, 32'h1122_3344, 32'h0,        0, 0, 4'b0000, 32'h0,        WD,           1, 2'd0});
        vq.push_back('{OP_LB,  32'h0000_1003, 32'h1122_3344, 32'h80FF_1234, 1, 0, 4'b1000, 32'h4444_4444, 32'hFFFF_FF80, 1, 2'd0});
        vq.push_back('{OP_LBU, 32'h0000_1001, 32'h1122_3344, 32'h1234_F0AB, 1, 0, 4'b0010, 32'h4444_4444, 32'h0000_00F0, 1, 2'd0});
        vq.push_back('{OP_LH,  32'h0000_2002, 32'h1122_3344, 32'h8001_7FFF, 1, 0, 4'b1100, 32'h3344_3344, 32'hFFFF_8001, 1, 2'd0});
        vq.push_back('{OP_LHU, 32'h0000_2000, 32'h1122_3344, 32'h1234_9ABC, 1, 0, 4'b0011, 32'h3344_3344, 32'h0000_9ABC, 1, 2'd0});
        vq.push_back('{OP_LW,  32'h0000_0004, 32'h1122_3344, 32'hDEAD_BEEF, 1, 0, 4'b1111, 32'h1122_3344, 32'hDEAD_BEEF, 1, 2'd0});
        vq.push_back('{OP_SH,  32'h0000_2002, 32'h0000_BEEF, 32'h0,        1, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0, 2'd0});
        vq.push_back('{OP_SB,  32'h0000_3001, 32'h0000_00A5, 32'h0,        1, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0,        0, 2'd0});
        vq.push_back('{OP_SW,  32'h0000_3004, 32'h1234_5678, 32'h0,        1, 1, 4'b1111, 32'h1234_5678, 32'h0,        0, 2'd0});
        vq.push_back('{OP_LW,  32'h0000_0006, 32'h0,         32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        0, 2'd1});
        vq.push_back('{OP_LH,  32'h0000_0001, 32'h0,         32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        0, 2'd1});
        vq.push_back('{OP_SH,  32'h0000_0003, 32'h0,         32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        0, 2'd2});
        vq.push_back('{OP_SW,  32'h0000_0002, 32'h0,         32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        0, 2'd2});
        vq.push_back('{OP_SB,  32'h0000_0003, 32'h0000_0042, 32'h0,        1, 1, 4'b1000, 32'h4242_4242, 32'h0,        0, 2'd0});
`ifdef LLSC_EN
        vq.push_back('{OP_LL,  32'h0000_0040, 32'h1122_3344, 32'hAAAA_5555, 1, 0, 4'b1111, 32'h1122_3344, 32'hAAAA_5555, 1, 2'd0});
        vq.push_back('{OP_SC,  32'h0000_0040, 32'h0000_0077, 32'h0,        1, 1, 4'b1111, 32'h0000_0077, 32'h1,        1, 2'd0});
        vq.push_back('{OP_SC,  32'h0000_0040, 32'h0000_0077, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 2'd0});
`else
        vq.push_back('{OP_LL,  32'h0000_0040, 32'h1122_3344, 32'h0,        0, 0, 4'b0000, 32'h0,        WD,           1, 2'd0});
        vq.push_back('{OP_SC,  32'h0000_0040, 32'h0000_0077, 32'h0,        0, 0, 4'b0000, 32'h0,        WD,           1, 2'd0});
`endif

        // Reset: combinational outputs forced low even with a misaligned load pending.
        i_aluop = OP_LW; i_addr = 32'h0000_0006;
        #1;
        chk("rst_o_wreg", o_wreg, 0);
        chk("rst_o_wd", o_wd, 0);
        chk("rst_o_wdata", o_wdata, 0);
        chk("rst_stall", stallreq, 0);
        chk("rst_exc", exc_code, 0);
        tick();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_sel", bus_sel, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        rst = 1'b0;
        i_aluop = 8'h25;
        tick();

        for (int k = 0; k < vq.size(); k++) run(vq[k]);

        // Ack in IDLE must not disturb a pass-through op.
        i_aluop = 8'h25; i_wdata = WD; bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        tick();
        bus_ack = 1'b0;
        chk("idle_ack_req", bus_req, 0);
        chk("idle_ack_wreg", o_wreg, 1);
        chk("idle_ack_wdata", o_wdata, WD);

        // LW with late ack, aborted by reset while BUSY.
        i_aluop = OP_LW; i_addr = 32'h0000_0100;
        tick();
        tick();
        tick();
        chk("hold_busy_req", bus_req, 1);
        chk("hold_busy_stall", stallreq, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_aluop = 8'h25;
        #1;
        chk("abort_req", bus_req, 0);
        chk("abort_stall", stallreq, 0);
        chk("abort_sel", bus_sel, 0);
        bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
        tick();
        bus_ack = 1'b0;
        chk("late_ack_req", bus_req, 0);
        chk("late_ack_stall", stallreq, 0);
        chk("late_ack_wreg", o_wreg, 1);
        chk("late_ack_wdata", o_wdata, WD);
        tick();
        chk("late_ack_idle_wreg", o_wreg, 1);
        chk("late_ack_idle_wdata", o_wdata, WD);

        // A fresh load after the abort still completes normally.
        run('{OP_LW, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 1, 0, 4'b1111, 32'h0, 32'h0BAD_F00D, 1, 2'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 i_wd  in  5  destination register address from EX/MEM register.
REQ-004 i_wreg  in  1  register write enable from EX/MEM register.
REQ-005 i_wdata  in  32  ALU result from EX/MEM register.
REQ-006 i_aluop  in  8  operation code; selects load/store kind.
REQ-007 i_addr  in  32  effective memory byte address.
REQ-008 i_reg2  in  32  store data (rt value).
REQ-009 bus_req  out  1  data-bus request, registered.
REQ-010 bus_we  out  1  1 = write, registered.
REQ-011 bus_sel  out  4  byte-lane enables, bit n = byte addr[1:0]==n, registered.
REQ-012 bus_addr  out  32  word-aligned address {i_addr[31:2],2'b00}, registered.
REQ-013 bus_wdata  out  32  store data replicated to lanes, registered.
REQ-014 bus_rdata  in  32  read data, valid when bus_ack=1.
REQ-015 bus_ack  in  1  one-cycle completion pulse.
REQ-016 o_wd / o_wreg / o_wdata  out  5/1/32  result toward MEM/WB register.
REQ-017 stallreq  out  1  holds EX/MEM and earlier stages while 1.
REQ-018 exc_code  out  2  0 none, 1 ADEL (load misaligned), 2 ADES (store misaligned).

Function
REQ-019 FSM states IDLE, BUSY, DONE; non-memory aluop in IDLE: o_* = i_* combinationally, stallreq=0, zero added latency.
REQ-020 IDLE + aligned load/store: stallreq=1 same cycle, bus outputs loaded, next BUSY.
REQ-021 BUSY: bus_req=1, stallreq=1; on bus_ack=1 capture bus_rdata into rdata_q, bus_req=0 next cycle, next DONE.
REQ-022 DONE: stallreq=0, result presented, next IDLE; minimum load/store latency 3 cycles (IDLE, BUSY w/ immediate ack, DONE).
REQ-023 Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word, lane chosen by addr[1:0]; o_wreg=i_wreg.
REQ-024 Stores: SB sel=1<<a[1:0], SH sel=0011/1100, SW 1111; bus_wdata byte/half replicated; o_wreg=0.
REQ-025 Misalignment (half a[0]=1; word a[1:0]!=0): no bus access, exc_code set, o_wreg=0, stallreq=0, stays IDLE.
REQ-026 bus_ack in IDLE or DONE ignored; BUSY holds indefinitely without ack (no timeout).
REQ-027 exc_code=0 for all aligned or non-memory operations.

Reset
REQ-028 rst=1: state IDLE, bus_req=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0, rdata_q=0 next edge; combinational outputs o_wreg=0, o_wd=0, o_wdata=0, stallreq=0, exc_code=0 while rst=1.
REQ-029 Reset during BUSY aborts the access; an ack arriving in the cycle after reset is ignored.

Configuration
REQ-030 Macro LLSC_EN defined: LL = LW plus llbit<=1, lladdr<=i_addr[31:2] at DONE; SC with llbit=1 and matching address performs SW and writes o_wdata=1; otherwise no bus access, o_wdata=0, o_wreg=1, one-cycle pass-through; every SC clears llbit; rst clears llbit.
REQ-031 LLSC_EN undefined: no llbit/lladdr state; LL/SC aluops treated as non-memory pass-through.

Structure
REQ-032 Aluop codes, FSM state encodings, exc_code values and bus widths live in the shared defines file.
REQ-033 Combinational lane select/extension isolated in sub-module mem_align; mem_access owns FSM and registers.

Verification
REQ-034 LB addr 0x1003, ack in 1st BUSY cycle, rdata 0x80FF_1234 -> o_wdata 0xFFFF_FF80, stallreq high 2 cycles.
REQ-035 SH addr 0x2002, reg2 0x0000_BEEF -> bus_sel 1100, bus_wdata 0xBEEF_BEEF, bus_addr 0x2000, o_wreg 0.
REQ-036 LW addr 0x0006 -> exc_code 1, bus_req never asserted, o_wreg 0, stallreq 0.
REQ-037 LW with ack delayed 5 cycles, rst pulsed at cycle 3 -> state IDLE, bus_req 0, late ack ignored.
REQ-038 LLSC_EN: LL 0x40, SC 0x40 -> store issued, o_wdata 1; second SC 0x40 -> no bus_req, o_wdata 0.
